// File: rtl/gj_sequencer.sv
// Gauss-Jordan inversion control sequencer.
// Issues probe/swap/norm/elim row commands, one outstanding at a time.
module gj_sequencer #(
  parameter int N  = 5,
  parameter int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          singular,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [1:0]    cmd_op,
  output logic [RW-1:0] cmd_row_a,
  output logic [RW-1:0] cmd_row_b,
  output logic [RW-1:0] cmd_col,
  input  logic          resp_valid,
  input  logic          resp_zero
);

  localparam logic [1:0] OP_PROBE = 2'd0;
  localparam logic [1:0] OP_SWAP  = 2'd1;
  localparam logic [1:0] OP_NORM  = 2'd2;
  localparam logic [1:0] OP_ELIM  = 2'd3;

  localparam logic [RW-1:0] LAST = RW'(N - 1);
  localparam logic [RW-1:0] ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_SWAP,
    S_NORM,
    S_ELIM,
    S_FINISH
  } state_t;

  state_t        state;
  logic [RW-1:0] k;
  logic [RW-1:0] r;
  logic [RW-1:0] i;
  logic          wait_resp;

  logic [RW-1:0] k_inc;
  logic [RW-1:0] r_inc;
  logic [RW-1:0] i_inc;
  logic [RW-1:0] i_nxt;
  logic [RW-1:0] i_first;
  logic          elim_last;

  // Next elimination row skips the pivot row; first one is row 0 unless k is 0.
  assign k_inc     = k + 1'b1;
  assign r_inc     = r + 1'b1;
  assign i_inc     = i + 1'b1;
  assign i_nxt     = (i_inc == k) ? (i + RW'(2)) : i_inc;
  assign i_first   = (k == ZERO) ? RW'(1) : ZERO;
  assign elim_last = (i == LAST) || ((i_inc == k) && (k == LAST));

  // Sequencer FSM with registered command and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      r         <= '0;
      i         <= '0;
      wait_resp <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      singular  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_row_a <= '0;
      cmd_row_b <= '0;
      cmd_col   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            k         <= '0;
            r         <= '0;
            i         <= '0;
            singular  <= 1'b0;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            cmd_op    <= OP_PROBE;
            cmd_row_a <= '0;
            cmd_row_b <= '0;
            cmd_col   <= '0;
            state     <= S_PROBE;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            wait_resp <= 1'b1;
          end else if (wait_resp && resp_valid) begin
            wait_resp <= 1'b0;
            unique case (state)
              S_PROBE: begin
                if (!resp_zero) begin
                  cmd_valid <= 1'b1;
                  cmd_row_a <= k;
                  cmd_col   <= k;
                  if (r == k) begin
                    cmd_op    <= OP_NORM;
                    cmd_row_b <= '0;
                    state     <= S_NORM;
                  end else begin
                    cmd_op    <= OP_SWAP;
                    cmd_row_b <= r;
                    state     <= S_SWAP;
                  end
                end else if (r != LAST) begin
                  r         <= r_inc;
                  cmd_valid <= 1'b1;
                  cmd_op    <= OP_PROBE;
                  cmd_row_a <= r_inc;
                  cmd_row_b <= '0;
                  cmd_col   <= k;
                end else begin
                  singular  <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cmd_op    <= '0;
                  cmd_row_a <= '0;
                  cmd_row_b <= '0;
                  cmd_col   <= '0;
                  state     <= S_FINISH;
                end
              end
              S_SWAP: begin
                cmd_valid <= 1'b1;
                cmd_op    <= OP_NORM;
                cmd_row_a <= k;
                cmd_row_b <= '0;
                cmd_col   <= k;
                state     <= S_NORM;
              end
              S_NORM: begin
                i         <= i_first;
                cmd_valid <= 1'b1;
                cmd_op    <= OP_ELIM;
                cmd_row_a <= k;
                cmd_row_b <= i_first;
                cmd_col   <= k;
                state     <= S_ELIM;
              end
              S_ELIM: begin
                if (!elim_last) begin
                  i         <= i_nxt;
                  cmd_valid <= 1'b1;
                  cmd_row_b <= i_nxt;
                end else if (k == LAST) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cmd_op    <= '0;
                  cmd_row_a <= '0;
                  cmd_row_b <= '0;
                  cmd_col   <= '0;
                  state     <= S_FINISH;
                end else begin
                  k         <= k_inc;
                  r         <= k_inc;
                  cmd_valid <= 1'b1;
                  cmd_op    <= OP_PROBE;
                  cmd_row_a <= k_inc;
                  cmd_row_b <= '0;
                  cmd_col   <= k_inc;
                  state     <= S_PROBE;
                end
              end
              default: begin
                state <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
